// File: rtl/bus_xfer_pkg.sv
// Shared encodings for the tristate-bus transfer controller: opcodes, FSM states
// and the agent-index width helper.
package bus_xfer_pkg;

   localparam logic [1:0] OP_MOV = 2'b00;
   localparam logic [1:0] OP_LDI = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_LATCH,
      ST_IMM,
      ST_CLR,
      ST_TURN
   } state_t;

   // Index width for n agents; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot decoder with enable; an out-of-range index yields all zeros.
module onehot_dec #(
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic [AW-1:0] idx,
   input  logic          en,
   output logic [N-1:0]  onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < N; i++) begin
         if (en && (idx == AW'(i))) onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Bus transfer initiator: accepts one MOV/LDI/CLR/NOP command at a time and
// sequences the registered drive/load/clear strobes with a turnaround cycle.
module bus_xfer_ctrl
   import bus_xfer_pkg::*;
#(
   parameter  int N_AGENTS = 4,
   parameter  int DW       = 4,
   localparam int AW       = idx_w(N_AGENTS)
) (
   input  logic                clk,
   input  logic                grst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [AW-1:0]       req_src,
   input  logic [AW-1:0]       req_dst,
   output logic [N_AGENTS-1:0] ws,
   output logic [N_AGENTS-1:0] rs_bus,
   output logic [N_AGENTS-1:0] rs_imm,
   output logic [N_AGENTS-1:0] lrst,
   input  logic [DW-1:0]       bus,
   output logic [DW-1:0]       xfer_data,
   output logic                done,
   output logic                err
);

   state_t        state;
   logic [AW-1:0] src_q;
   logic [AW-1:0] dst_q;

   logic          accept;
   logic          src_ok;
   logic          dst_ok;
   logic          mov_ok;
   logic          cmd_err;
   logic [AW-1:0] ws_idx;
   logic          ws_en;
   logic          rs_bus_en;
   logic          rs_imm_en;
   logic          lrst_en;

   logic [N_AGENTS-1:0] ws_nx;
   logic [N_AGENTS-1:0] rs_bus_nx;
   logic [N_AGENTS-1:0] rs_imm_nx;
   logic [N_AGENTS-1:0] lrst_nx;

   function automatic logic in_range(input logic [AW-1:0] idx);
      return int'(idx) < N_AGENTS;
   endfunction

   assign accept  = req_valid && req_ready && (state == ST_IDLE);
   assign src_ok  = in_range(req_src);
   assign dst_ok  = in_range(req_dst);
   assign mov_ok  = (req_op == OP_MOV) && src_ok && dst_ok && (req_src != req_dst);
   assign cmd_err = ((req_op == OP_MOV) && !mov_ok) ||
                    (((req_op == OP_LDI) || (req_op == OP_CLR)) && !dst_ok);

   // Strobes are decoded one cycle ahead and registered, so each enable below
   // describes what the outputs must show in the state being entered.
   assign ws_idx    = (state == ST_IDLE) ? req_src : src_q;
   assign ws_en     = (accept && mov_ok) || (state == ST_DRIVE);
   assign rs_bus_en = (state == ST_DRIVE);
   assign rs_imm_en = accept && (req_op == OP_LDI) && dst_ok;
   assign lrst_en   = accept && (req_op == OP_CLR) && dst_ok;

   onehot_dec #(.N(N_AGENTS), .AW(AW)) u_dec_ws (
      .idx    (ws_idx),
      .en     (ws_en),
      .onehot (ws_nx)
   );

   onehot_dec #(.N(N_AGENTS), .AW(AW)) u_dec_rs_bus (
      .idx    (dst_q),
      .en     (rs_bus_en),
      .onehot (rs_bus_nx)
   );

   onehot_dec #(.N(N_AGENTS), .AW(AW)) u_dec_rs_imm (
      .idx    (req_dst),
      .en     (rs_imm_en),
      .onehot (rs_imm_nx)
   );

   onehot_dec #(.N(N_AGENTS), .AW(AW)) u_dec_lrst (
      .idx    (req_dst),
      .en     (lrst_en),
      .onehot (lrst_nx)
   );

   always_ff @(posedge clk) begin
      if (grst) begin
         state     <= ST_IDLE;
         req_ready <= 1'b1;
         src_q     <= '0;
         dst_q     <= '0;
         ws        <= '0;
         rs_bus    <= '0;
         rs_imm    <= '0;
         lrst      <= '0;
         xfer_data <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         ws     <= ws_nx;
         rs_bus <= rs_bus_nx;
         rs_imm <= rs_imm_nx;
         lrst   <= lrst_nx;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  src_q     <= req_src;
                  dst_q     <= req_dst;
                  req_ready <= 1'b0;
                  if (cmd_err) begin
                     state <= ST_TURN;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     case (req_op)
                        OP_MOV:  state <= ST_DRIVE;
                        OP_LDI:  state <= ST_IMM;
                        OP_CLR:  state <= ST_CLR;
                        default: begin
                           state <= ST_TURN;
                           done  <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            ST_DRIVE: state <= ST_LATCH;
            ST_LATCH: begin
               // Source has driven for a full cycle; capture alongside the destination.
               xfer_data <= bus;
               state     <= ST_TURN;
               done      <= 1'b1;
            end
            ST_IMM, ST_CLR: begin
               state <= ST_TURN;
               done  <= 1'b1;
            end
            ST_TURN: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: a register-file/bus model driven by the DUT strobes and
// a command-level reference model of latency, strobes, data movement and errors.
module tb_bus_xfer_ctrl;
   import bus_xfer_pkg::*;

   localparam int N  = 4;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          grst;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_op;
   logic [1:0]    req_src;
   logic [1:0]    req_dst;
   logic [N-1:0]  ws;
   logic [N-1:0]  rs_bus;
   logic [N-1:0]  rs_imm;
   logic [N-1:0]  lrst;
   logic [DW-1:0] bus_m;
   logic [DW-1:0] xfer_data;
   logic          done;
   logic          err;

   logic          preload;
   logic [DW-1:0] regs  [N];
   logic [DW-1:0] mregs [N];
   logic [DW-1:0] mxfer;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int accepted = 0;

   always #5 clk = ~clk;

   bus_xfer_ctrl #(.N_AGENTS(N), .DW(DW)) dut (
      .clk       (clk),
      .grst      (grst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_src   (req_src),
      .req_dst   (req_dst),
      .ws        (ws),
      .rs_bus    (rs_bus),
      .rs_imm    (rs_imm),
      .lrst      (lrst),
      .bus       (bus_m),
      .xfer_data (xfer_data),
      .done      (done),
      .err       (err)
   );

   function automatic logic [DW-1:0] imm_of(input int i);
      return DW'(i * 3 + 5);
   endfunction

   function automatic logic [DW-1:0] init_of(input int i);
      logic [4*DW-1:0] tbl;
      tbl = 16'hC73A;
      return tbl[i*DW +: DW];
   endfunction

   // Agents drive the bus when enabled; OR-merge exposes any contention.
   always_comb begin
      bus_m = '0;
      for (int i = 0; i < N; i++) if (ws[i]) bus_m = bus_m | regs[i];
   end

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (preload)        regs[i] <= init_of(i);
         else if (lrst[i])   regs[i] <= '0;
         else if (rs_imm[i]) regs[i] <= imm_of(i);
         else if (rs_bus[i]) regs[i] <= bus_m;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample on the falling edge, then check the bus invariants.
   task automatic tick();
      @(negedge clk);
      done_cnt += int'(done);
      if (!grst) begin
         chk("inv_ws_onehot0", 32'($countones(ws) <= 1), 32'd1);
         chk("inv_ws_idle_turn", 32'(!((done || req_ready) && (ws != '0))), 32'd1);
         chk("inv_load_onehot0", 32'(($countones(rs_bus) <= 1) && ($countones(rs_imm) <= 1) &&
                                     ($countones(lrst) <= 1)), 32'd1);
         chk("inv_one_load_kind", 32'((int'(rs_bus != '0) + int'(rs_imm != '0) + int'(lrst != '0)) <= 1), 32'd1);
         chk("inv_rs_bus_src", 32'((rs_bus == '0) || ((ws != '0) && ((ws & rs_bus) == '0))), 32'd1);
      end
   endtask

   task automatic scramble();
      req_op  = 2'($urandom);
      req_src = 2'($urandom);
      req_dst = 2'($urandom);
   endtask

   task automatic wait_ready();
      for (int w = 0; w < 8 && !req_ready; w++) tick();
      chk("ready_before_cmd", 32'(req_ready), 32'd1);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst);
      logic         e;
      logic         mv;
      int           lat;
      logic [N-1:0] ews, ebus, eimm, elrst;
      e   = (op == OP_MOV) && (src == dst);
      mv  = (op == OP_MOV) && !e;
      lat = mv ? 3 : ((op == OP_LDI) || (op == OP_CLR)) ? 2 : 1;
      wait_ready();
      req_valid = 1'b1;
      req_op    = op;
      req_src   = src;
      req_dst   = dst;
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k == 1) begin
            req_valid = 1'b0;
            scramble();
         end
         ews   = (mv && k < 3)            ? (N'(1) << src) : '0;
         ebus  = (mv && k == 2)           ? (N'(1) << dst) : '0;
         eimm  = (op == OP_LDI && k == 1) ? (N'(1) << dst) : '0;
         elrst = (op == OP_CLR && k == 1) ? (N'(1) << dst) : '0;
         chk("cmd_ws", 32'(ws), 32'(ews));
         chk("cmd_rs_bus", 32'(rs_bus), 32'(ebus));
         chk("cmd_rs_imm", 32'(rs_imm), 32'(eimm));
         chk("cmd_lrst", 32'(lrst), 32'(elrst));
         chk("cmd_done", 32'(done), 32'(k == lat));
         chk("cmd_err", 32'(err), 32'(e && k == lat));
         chk("cmd_ready_low", 32'(req_ready), 32'd0);
      end
      accepted++;
      tick();
      chk("post_done_low", 32'(done), 32'd0);
      chk("post_ready", 32'(req_ready), 32'd1);
      if (mv) begin
         mxfer      = mregs[src];
         mregs[dst] = mregs[src];
      end else if (op == OP_LDI) begin
         mregs[dst] = imm_of(int'(dst));
      end else if (op == OP_CLR) begin
         mregs[dst] = '0;
      end
      chk("xfer_data", 32'(xfer_data), 32'(mxfer));
      chk("dst_reg", 32'(regs[dst]), 32'(mregs[dst]));
   endtask

   initial begin
      grst      = 1'b1;
      preload   = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      req_src   = '0;
      req_dst   = '0;
      for (int i = 0; i < N; i++) mregs[i] = init_of(i);
      mxfer = '0;
      tick();
      tick();
      grst    = 1'b0;
      preload = 1'b0;

      // Reset state after three idle cycles.
      repeat (3) tick();
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_strobes", 32'({ws, rs_bus, rs_imm, lrst}), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_xfer", 32'(xfer_data), 32'd0);

      // MOV 0 -> 2 with agent0 holding 4'hA.
      run_cmd(OP_MOV, 2'd0, 2'd2);
      chk("mov_xfer_A", 32'(xfer_data), 32'hA);

      // LDI dst=1 then CLR dst=3 with valid held high throughout.
      wait_ready();
      req_valid = 1'b1;
      req_op    = OP_LDI;
      req_dst   = 2'd1;
      tick();
      req_op  = OP_CLR;
      req_dst = 2'd3;
      chk("b2b_rs_imm", 32'(rs_imm), 32'b0010);
      chk("b2b_ready_low1", 32'(req_ready), 32'd0);
      tick();
      chk("b2b_ldi_done", 32'(done), 32'd1);
      chk("b2b_lrst_early", 32'(lrst), 32'd0);
      chk("b2b_ready_low2", 32'(req_ready), 32'd0);
      tick();
      chk("b2b_ready_back", 32'(req_ready), 32'd1);
      chk("b2b_lrst_idle", 32'(lrst), 32'd0);
      tick();
      req_valid = 1'b0;
      chk("b2b_lrst", 32'(lrst), 32'b1000);
      chk("b2b_rs_imm_off", 32'(rs_imm), 32'd0);
      tick();
      chk("b2b_clr_done", 32'(done), 32'd1);
      chk("b2b_clr_err", 32'(err), 32'd0);
      tick();
      accepted += 2;
      mregs[1] = imm_of(1);
      mregs[3] = '0;
      chk("b2b_reg1", 32'(regs[1]), 32'(mregs[1]));
      chk("b2b_reg3", 32'(regs[3]), 32'(mregs[3]));

      // MOV with src == dst is an error: no strobes, done+err next cycle.
      run_cmd(OP_MOV, 2'd2, 2'd2);

      // Reset during LATCH of MOV 1 -> 0 drops the command.
      wait_ready();
      req_valid = 1'b1;
      req_op    = OP_MOV;
      req_src   = 2'd1;
      req_dst   = 2'd0;
      tick();
      req_valid = 1'b0;
      chk("abort_drive_ws", 32'(ws), 32'b0010);
      tick();
      chk("abort_latch_rs_bus", 32'(rs_bus), 32'b0001);
      grst = 1'b1;
      tick();
      chk("abort_strobes", 32'({ws, rs_bus, rs_imm, lrst}), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
      chk("abort_xfer", 32'(xfer_data), 32'd0);
      grst = 1'b0;
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
      mxfer    = '0;
      // Destination strobe was already high at the reset edge, so agent0 loaded.
      mregs[0] = mregs[1];
      chk("abort_reg0", 32'(regs[0]), 32'(mregs[0]));

      // Random command stream with idle gaps.
      for (int n = 0; n < 500; n++) begin
         int gap;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            scramble();
            tick();
         end
         run_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      repeat (2) tick();
      chk("done_count", 32'(done_cnt), 32'(accepted));
      for (int i = 0; i < N; i++) chk("final_reg", 32'(regs[i]), 32'(mregs[i]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Control-side initiator for the shared tristate data bus used by the register file. It accepts one transfer command at a time through a valid/ready handshake. It sequences the per-register drive (ws), load-from-bus (rs_bus), load-immediate (rs_imm) and local-clear (lrst) strobes so that exactly one agent drives the bus and the destination samples stable data. A turnaround cycle separates transfers, and each completed transfer is reported with a done pulse.

Parameters:
N_AGENTS, 4, number of bus agents (registers); index width AW = clog2(N_AGENTS)
DW, 4, bus data width

Ports:
clk  input  1  system clock, rising edge
grst  input  1  global reset, synchronous, active-high
req_valid  input  1  command valid
req_ready  output  1  command accepted when valid&ready
req_op  input  2  00 MOV, 01 LDI, 10 CLR, 11 NOP
req_src  input  AW  source agent index (MOV only)
req_dst  input  AW  destination agent index
ws  output  N_AGENTS  one-hot bus-drive enables
rs_bus  output  N_AGENTS  load-from-bus strobes
rs_imm  output  N_AGENTS  load-immediate strobes
lrst  output  N_AGENTS  local clear strobes
bus  input  DW  bus monitor (observe only, never driven)
xfer_data  output  DW  value captured from bus on last MOV
done  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- All state and outputs are registered. Clock is clk; grst is synchronous, active-high.
- Reset values: state IDLE, req_ready=1, ws/rs_bus/rs_imm/lrst=0, xfer_data=0, done=0, err=0.
- States: IDLE, DRIVE, LATCH, IMM, CLR, TURN.
- IDLE:
  - req_ready=1; all strobes 0.
  - On valid&ready, latch op/src/dst. Next state: MOV→DRIVE, LDI→IMM, CLR→CLR, NOP→TURN.
  - MOV with src==dst → TURN with error flagged.
- DRIVE: ws[src]=1 only. Bus settles. Next state LATCH.
- LATCH:
  - ws[src]=1 and rs_bus[dst]=1.
  - xfer_data<=bus at the closing edge; the destination samples at the same edge.
  - Next state TURN.
- IMM: rs_imm[dst]=1 for one cycle. Next state TURN.
- CLR: lrst[dst]=1 for one cycle. Next state TURN.
- TURN:
  - All strobes 0 (bus floats).
  - done=1; err=1 if the flagged error is set.
  - Next state IDLE.
- Latency from acceptance edge to done cycle:
  - MOV: 3 cycles.
  - LDI, CLR: 2 cycles.
  - NOP and error case: 1 cycle.
- Throughput: one command per (latency+1) cycles. req_ready is low in every non-IDLE state, so no back-to-back acceptance.
- Invariants, checked in every cycle:
  - popcount(ws) ≤ 1.
  - ws is never asserted in TURN or IDLE.
  - rs_bus, rs_imm and lrst are each at most one-hot, and at most one of the three is non-zero.
  - rs_bus[i] implies ws[j] with j≠i.
- Out-of-range indices (≥N_AGENTS, when N_AGENTS is not a power of 2) are treated as error: → TURN with err.
- Reset mid-operation: the next edge forces IDLE, all strobes 0, done/err 0. The in-flight command is dropped with no done.
- Command inputs are ignored while req_ready=0; changing them mid-transfer has no effect.
- xfer_data holds its value until the next successful MOV.

Decomposition:
- Package bus_xfer_pkg holds:
  - the op encodings (OP_MOV, OP_LDI, OP_CLR, OP_NOP);
  - the state enum;
  - the AW helper function.
- One sub-module, onehot_dec (index → N_AGENTS one-hot with enable), instanced for ws, rs_bus, rs_imm and lrst generation.

Test Plan:
- Reset, then idle 3 cycles → req_ready=1, all strobes 0, done=0.
- MOV src=0, dst=2, bus model: agent0 drives 4'hA when ws[0] →
  - ws=0001 for 2 cycles;
  - rs_bus=0100 in the 2nd of those cycles;
  - xfer_data=4'hA;
  - done 3 cycles after acceptance, err=0.
- LDI dst=1 then CLR dst=3, back-to-back valid →
  - rs_imm=0010 one cycle, then done;
  - second command accepted only when req_ready returns;
  - lrst=1000 one cycle, then done.
- MOV src=2, dst=2 → no strobes at all; done=1 and err=1 one cycle after acceptance.
- grst asserted during LATCH of MOV 1→0 → next cycle all strobes 0, IDLE, no done, xfer_data=0.
- Random 500-command stream with a bus contention assertion → the invariants never fire and the done count equals the accepted command count.
